// File: rtl/ssd_block_engine.sv
// Stereo block-matching cost engine: aligns left/right rows, forms per-pixel squared (SSD) or
// absolute (SAD) differences and accumulates one cost per block. Tracker option: BEST_MATCH_EN.
module ssd_block_engine #(
    parameter  int unsigned BLOCK_W = 6,
    parameter  int unsigned BLOCK_H = 6,
    parameter  int unsigned PIX_W   = 8,
    localparam int unsigned SUM_W   = 2 * PIX_W + $clog2(BLOCK_W * BLOCK_H + 1),
    localparam int unsigned ROW_W   = BLOCK_W * PIX_W,
    localparam int unsigned OFF_W   = $clog2(BLOCK_W),
    localparam int unsigned CNT_W   = $clog2(BLOCK_H + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             row_valid_in,
    output logic             row_ready_out,
    input  logic             row_last_in,
    input  logic [ROW_W-1:0] left_front_in,
    input  logic [ROW_W-1:0] left_back_in,
    input  logic [ROW_W-1:0] right_front_in,
    input  logic [ROW_W-1:0] right_back_in,
    input  logic [OFF_W-1:0] left_offset_in,
    input  logic [OFF_W-1:0] right_offset_in,
    input  logic             mode_sad_in,
    output logic             ssd_valid_out,
    input  logic             ssd_ready_in,
    output logic [SUM_W-1:0] ssd_out,
    output logic [CNT_W-1:0] ssd_rows_out
`ifdef BEST_MATCH_EN
    ,
    input  logic [7:0]       disp_idx_in,
    input  logic             disp_last_in,
    output logic             best_valid_out,
    output logic [SUM_W-1:0] best_ssd_out,
    output logic [7:0]       best_idx_out
`endif
);

    typedef logic [BLOCK_W-1:0][PIX_W-1:0] row_t;
    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

    state_e                          state_q;
    logic                            row_ready_q, valid_q, mode_q;
    logic [CNT_W-1:0]                cnt_q, rows_next;
    logic [1:0]                      drain_q;
    logic                            accept, close_blk;
    logic                            s1_valid_q, s1_first_q, s2_valid_q, s2_first_q;
    row_t                            s1_left_q, s1_right_q;
    logic [BLOCK_W-1:0][PIX_W-1:0]   diff;
    logic [BLOCK_W-1:0][2*PIX_W-1:0] term_d, s2_term_q;
    logic [SUM_W-1:0]                row_sum, acc_q;

    // Window is pixels k..k+BLOCK_W-1 of the concatenation {back, front}.
    function automatic row_t align_row(input row_t front, input row_t back,
                                       input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0]   k;
        logic [2*ROW_W-1:0] cat;
        k   = (32'(off) >= BLOCK_W) ? OFF_W'(BLOCK_W - 1) : off;
        cat = {back, front} >> ((BLOCK_W - 32'(k)) * PIX_W);
        return cat[ROW_W-1:0];
    endfunction

    assign accept    = row_valid_in && row_ready_q;
    assign rows_next = (state_q == StIdle) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign close_blk = row_last_in || (rows_next == CNT_W'(BLOCK_H));

    always_comb begin
        diff   = '0;
        term_d = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            diff[i]   = (s1_left_q[i] > s1_right_q[i]) ? s1_left_q[i] - s1_right_q[i]
                                                       : s1_right_q[i] - s1_left_q[i];
            term_d[i] = mode_q ? {{PIX_W{1'b0}}, diff[i]}
                               : {{PIX_W{1'b0}}, diff[i]} * {{PIX_W{1'b0}}, diff[i]};
        end
    end

    always_comb begin
        row_sum = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            row_sum = row_sum + SUM_W'(s2_term_q[i]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_left_q  <= '0;
            s1_right_q <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_term_q  <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_first_q <= (state_q == StIdle);
            if (accept) begin
                s1_left_q  <= align_row(left_front_in, left_back_in, left_offset_in);
                s1_right_q <= align_row(right_front_in, right_back_in, right_offset_in);
            end
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_term_q  <= term_d;
            // First row of a block overwrites whatever the previous block left behind.
            if (s2_valid_q) begin
                acc_q <= s2_first_q ? row_sum : acc_q + row_sum;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            row_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            drain_q     <= '0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    row_ready_q <= 1'b1;
                    if (accept) begin
                        cnt_q <= rows_next;
                        if (state_q == StIdle) begin
                            mode_q <= mode_sad_in;
                        end
                        if (close_blk) begin
                            state_q     <= StDrain;
                            row_ready_q <= 1'b0;
                            drain_q     <= 2'd2;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == 2'd0) begin
                        state_q <= StHold;
                        valid_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
                StHold: begin
                    if (ssd_ready_in) begin
                        state_q     <= StIdle;
                        valid_q     <= 1'b0;
                        row_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign row_ready_out = row_ready_q;
    assign ssd_valid_out = valid_q;
    assign ssd_out       = acc_q;
    assign ssd_rows_out  = cnt_q;

`ifdef BEST_MATCH_EN
    logic [7:0]       idx_q, min_idx_q, best_idx_q;
    logic             last_q, best_valid_q, take;
    logic [SUM_W-1:0] min_q, best_ssd_q;

    assign take = acc_q < min_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx_q        <= '0;
            last_q       <= 1'b0;
            min_q        <= '1;
            min_idx_q    <= '1;
            best_valid_q <= 1'b0;
            best_ssd_q   <= '0;
            best_idx_q   <= '0;
        end else begin
            best_valid_q <= 1'b0;
            if (accept && (state_q == StIdle)) begin
                idx_q  <= disp_idx_in;
                last_q <= disp_last_in;
            end
            if (valid_q && ssd_ready_in) begin
                if (last_q) begin
                    best_valid_q <= 1'b1;
                    best_ssd_q   <= take ? acc_q : min_q;
                    best_idx_q   <= take ? idx_q : min_idx_q;
                    min_q        <= '1;
                    min_idx_q    <= '1;
                end else if (take) begin
                    min_q     <= acc_q;
                    min_idx_q <= idx_q;
                end
            end
        end
    end

    assign best_valid_out = best_valid_q;
    assign best_ssd_out   = best_ssd_q;
    assign best_idx_out   = best_idx_q;
`endif

endmodule

// File: tb/tb_ssd_block_engine.sv
// Self-checking bench for ssd_block_engine: table of block vectors plus hand sequences for
// backpressure, mid-block reset and mode latching; costs checked through a scoreboard queue.
module tb_ssd_block_engine;

    localparam int unsigned BW = 6;
    localparam int unsigned BH = 6;
    localparam int unsigned PW = 8;
    localparam int unsigned SW = 2 * PW + $clog2(BW * BH + 1);

    typedef struct {
        logic [47:0] lf, lb, rf, rb;
        logic [2:0]  lk, rk;
        logic        mode;
        int          nrows;
        logic        use_last;
        int          cost;
        int          rows;
    } vec_t;

    typedef struct {
        int cost;
        int rows;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, row_valid, row_ready, row_last, mode, ssd_valid, ssd_ready;
    logic [47:0]   lf, lb, rf, rb;
    logic [2:0]    lk, rk;
    logic [SW-1:0] ssd;
    logic [2:0]    rows;
`ifdef BEST_MATCH_EN
    logic [7:0]    disp_idx, best_idx;
    logic          disp_last, best_valid;
    logic [SW-1:0] best_ssd;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ssd_block_engine #(.BLOCK_W(BW), .BLOCK_H(BH), .PIX_W(PW)) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .row_valid_in   (row_valid),
        .row_ready_out  (row_ready),
        .row_last_in    (row_last),
        .left_front_in  (lf),
        .left_back_in   (lb),
        .right_front_in (rf),
        .right_back_in  (rb),
        .left_offset_in (lk),
        .right_offset_in(rk),
        .mode_sad_in    (mode),
        .ssd_valid_out  (ssd_valid),
        .ssd_ready_in   (ssd_ready),
        .ssd_out        (ssd),
        .ssd_rows_out   (rows)
`ifdef BEST_MATCH_EN
        ,
        .disp_idx_in    (disp_idx),
        .disp_last_in   (disp_last),
        .best_valid_out (best_valid),
        .best_ssd_out   (best_ssd),
        .best_idx_out   (best_idx)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] lf_v, lb_v, rf_v, rb_v,
                                input logic [2:0] lk_v, rk_v, input logic mode_v,
                                input int n, input logic ul, input int cost, input int nr);
        vec_t v;
        v.lf = lf_v; v.lb = lb_v; v.rf = rf_v; v.rb = rb_v;
        v.lk = lk_v; v.rk = rk_v; v.mode = mode_v;
        v.nrows = n; v.use_last = ul; v.cost = cost; v.rows = nr;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.cost = v.cost;
        e.rows = v.rows;
        sb.push_back(e);
    endtask

    task automatic beat(input vec_t v, input logic last, input logic fin);
        int n;
        @(negedge clk);
        lf = v.lf; lb = v.lb; rf = v.rf; rb = v.rb;
        lk = v.lk; rk = v.rk; mode = v.mode;
        row_last = last;
        row_valid = 1'b1;
        n = 0;
        while (!row_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!row_ready) begin
            check("beat_accept_timeout", row_ready, 1);
            row_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (fin) last_acc_cyc = cyc;
    endtask

    task automatic idle_in();
        @(negedge clk);
        row_valid = 1'b0;
        row_last  = 1'b0;
    endtask

    task automatic run_block(input vec_t v);
        push_exp(v);
        for (int r = 0; r < v.nrows; r++) begin
            beat(v, v.use_last && (r == v.nrows - 1), r == v.nrows - 1);
        end
        idle_in();
    endtask

    task automatic drain_sb();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (ssd_valid && !prev_valid) check("latency", cyc - last_acc_cyc, 3);
            if (ssd_valid && ssd_ready) begin
                check("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("cost", ssd, e.cost);
                    check("rows", rows, e.rows);
                end
            end
        end
        prev_valid = ssd_valid;
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   n;
        rst_n = 1'b0; row_valid = 1'b0; row_last = 1'b0; mode = 1'b0; ssd_ready = 1'b1;
        lf = '0; lb = '0; rf = '0; rb = '0; lk = '0; rk = '0;
`ifdef BEST_MATCH_EN
        disp_idx = '0; disp_last = 1'b0;
`endif
        tbl[0] = mk({6{8'hFF}}, {6{8'hFF}}, '0, '0, 0, 0, 0, 6, 0, 2340900, 6);
        tbl[1] = mk({6{8'hFF}}, {6{8'hFF}}, '0, '0, 0, 0, 1, 6, 0, 9180, 6);
        tbl[2] = mk({6{8'd20}}, {6{8'd10}}, {6{8'h55}}, {6{8'd10}}, 2, 0, 0, 6, 0, 1200, 6);
        tbl[3] = mk({6{8'd5}}, {6{8'd5}}, {6{8'd4}}, {6{8'd4}}, 0, 0, 0, 2, 1, 12, 2);
        tbl[4] = mk({6{8'd3}}, {6{8'd1}}, '0, '0, 7, 0, 0, 1, 1, 46, 1);
        tbl[5] = mk('0, '0, {6{8'd8}}, '0, 0, 3, 1, 3, 1, 72, 3);
        tbl[6] = mk({6{8'd3}}, {6{8'd3}}, {6{8'd200}}, {6{8'd200}}, 0, 0, 1, 4, 1, 4728, 4);
        tbl[7] = mk({8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12},
                    {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, '0, '0, 1, 0, 0, 6, 0, 834, 6);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_row_ready", row_ready, 0);
        check("reset_valid", ssd_valid, 0);
        check("reset_cost", ssd, 0);
        check("reset_rows", rows, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_block(tbl[i]);

        // Mode sampled on the first row only: SSD 24/row for three rows.
        v = mk({6{8'd5}}, {6{8'd5}}, {6{8'd3}}, {6{8'd3}}, 0, 0, 0, 3, 1, 72, 3);
        push_exp(v);
        beat(v, 1'b0, 1'b0);
        v.mode = 1'b1;
        beat(v, 1'b0, 1'b0);
        beat(v, 1'b1, 1'b1);
        idle_in();
        drain_sb();

        // Backpressure in HOLD.
        @(posedge clk);
        #1 ssd_ready = 1'b0;
        run_block(tbl[0]);
        n = 0;
        while (!ssd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid", ssd_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_cost", ssd, 2340900);
            check("hold_rows", rows, 6);
            check("hold_row_ready", row_ready, 0);
        end
        @(posedge clk);
        #1 ssd_ready = 1'b1;
        run_block(tbl[4]);
        drain_sb();

        // Reset in the middle of a block discards the partial sum.
        for (int r = 0; r < 3; r++) beat(tbl[3], 1'b0, 1'b0);
        idle_in();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_row_ready", row_ready, 0);
        check("midrst_valid", ssd_valid, 0);
        check("midrst_cost", ssd, 0);
        check("midrst_rows", rows, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_block(tbl[0]);
        drain_sb();

`ifdef BEST_MATCH_EN
        begin
            vec_t bm[4];
            bm[0] = mk('0, {8'd5, 8'd5, 32'd0}, '0, '0, 0, 0, 0, 1, 1, 50, 1);
            bm[1] = mk('0, {8'd20, 40'd0}, '0, '0, 0, 0, 1, 1, 1, 20, 1);
            bm[2] = mk('0, {8'd20, 40'd0}, '0, '0, 0, 0, 1, 1, 1, 20, 1);
            bm[3] = mk('0, {8'd90, 40'd0}, '0, '0, 0, 0, 1, 1, 1, 90, 1);
            for (int i = 0; i < 4; i++) begin
                disp_idx  = 8'(i);
                disp_last = (i == 3);
                run_block(bm[i]);
            end
            n = 0;
            while (!best_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("best_valid", best_valid, 1);
            check("best_ssd", best_ssd, 20);
            check("best_idx", best_idx, 1);
            disp_last = 1'b0;
            drain_sb();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
